// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// coordinate, sync, blank and start-of-line/frame outputs, advanced by a pixel enable.
module vga_timing_gen #(
    parameter int   C_hres   = 640,
    parameter int   C_hfront = 16,
    parameter int   C_hsync  = 96,
    parameter int   C_hback  = 48,
    parameter int   C_vres   = 480,
    parameter int   C_vfront = 10,
    parameter int   C_vsync  = 2,
    parameter int   C_vback  = 33,
    parameter logic C_hpol   = 1'b0,
    parameter logic C_vpol   = 1'b0,
    parameter int   C_bits   = 10
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              ce,
    output logic [C_bits-1:0] x,
    output logic [C_bits-1:0] y,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              line_start,
    output logic              frame_start
);

    localparam int H_total = C_hres + C_hfront + C_hsync + C_hback;
    localparam int V_total = C_vres + C_vfront + C_vsync + C_vback;

    localparam logic [C_bits-1:0] L_hlast     = C_bits'(H_total - 1);
    localparam logic [C_bits-1:0] L_vlast     = C_bits'(V_total - 1);
    localparam logic [C_bits-1:0] L_hres      = C_bits'(C_hres);
    localparam logic [C_bits-1:0] L_vres      = C_bits'(C_vres);
    localparam logic [C_bits-1:0] L_hs_start  = C_bits'(C_hres + C_hfront);
    localparam logic [C_bits-1:0] L_hs_end    = C_bits'(C_hres + C_hfront + C_hsync);
    localparam logic [C_bits-1:0] L_vs_start  = C_bits'(C_vres + C_vfront);
    localparam logic [C_bits-1:0] L_vs_end    = C_bits'(C_vres + C_vfront + C_vsync);
    localparam logic [C_bits-1:0] L_zero      = '0;
    localparam logic [C_bits-1:0] L_one       = C_bits'(1);

    logic [C_bits-1:0] r_hcnt;
    logic [C_bits-1:0] r_vcnt;
    logic [C_bits-1:0] r_x;
    logic [C_bits-1:0] r_y;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_blank;
    logic              r_line_start;
    logic              r_frame_start;

    logic [C_bits-1:0] w_hcnt_nxt;
    logic [C_bits-1:0] w_vcnt_nxt;
    logic              w_hlast;
    logic              w_vlast;
    logic              w_hactive;
    logic              w_vactive;
    logic              w_hsync_win;
    logic              w_vsync_win;
    logic              w_at_line0;
    logic              w_at_frame0;

    assign w_hlast = (r_hcnt == L_hlast);
    assign w_vlast = (r_vcnt == L_vlast);

    // vcnt only moves on the last pixel of a line, so both wrap on the same edge
    always_comb begin
        w_hcnt_nxt = r_hcnt + L_one;
        w_vcnt_nxt = r_vcnt;
        if (w_hlast) begin
            w_hcnt_nxt = L_zero;
            if (w_vlast) begin
                w_vcnt_nxt = L_zero;
            end else begin
                w_vcnt_nxt = r_vcnt + L_one;
            end
        end
    end

    assign w_hactive   = (r_hcnt < L_hres);
    assign w_vactive   = (r_vcnt < L_vres);
    assign w_hsync_win = (r_hcnt >= L_hs_start) && (r_hcnt < L_hs_end);
    assign w_vsync_win = (r_vcnt >= L_vs_start) && (r_vcnt < L_vs_end);
    assign w_at_line0  = (r_hcnt == L_zero);
    assign w_at_frame0 = w_at_line0 && (r_vcnt == L_zero);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~C_hpol;
            r_vsync       <= ~C_vpol;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // start pulses are one clock wide even when ce stays low afterwards
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (ce) begin
                r_hcnt        <= w_hcnt_nxt;
                r_vcnt        <= w_vcnt_nxt;
                r_x           <= r_hcnt;
                r_y           <= r_vcnt;
                r_blank       <= ~(w_hactive & w_vactive);
                r_hsync       <= w_hsync_win ? C_hpol : ~C_hpol;
                r_vsync       <= w_vsync_win ? C_vpol : ~C_vpol;
                r_line_start  <= w_at_line0;
                r_frame_start <= w_at_frame0;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
